// File: rtl/instr_fetch_queue_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_queue_if
//   Bundles every bus that the fetch queue talks over: the instruction memory
//   request/response port, the decode-side instruction stream, the redirect
//   input and the flush status output.
//
// Handshake rules (all channels):
//   - A request transfers on a rising edge where imem_req_valid and
//     imem_req_ready are both 1. Once raised, valid and addr hold until that
//     transfer; the only exception is a redirect, which drops valid at once.
//   - imem_rsp_valid has no back-pressure. One response comes back for each
//     accepted request, and responses return in request order.
//   - An instruction transfers on a rising edge where instr_valid and
//     instr_ready are both 1. instr and instr_pc hold while instr_valid=1 and
//     instr_ready=0.
//   - redirect_valid is a one-cycle command and needs no handshake.
//
// Modports:
//   master - the fetch queue itself.
//   slave  - the environment: memory, decode and redirect source.
// ---------------------------------------------------------------------------
interface instr_fetch_queue_if;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush_busy;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data,
    output instr_valid, instr, instr_pc,
    input  instr_ready,
    input  redirect_valid, redirect_pc,
    output flush_busy
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data,
    input  instr_valid, instr, instr_pc,
    output instr_ready,
    output redirect_valid, redirect_pc,
    input  flush_busy
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// ---------------------------------------------------------------------------
// instr_fetch_queue
//   Sequential instruction fetch in front of decode. The block issues word
//   fetches to a pipelined memory whose latency can vary. It buffers the
//   returned words, each tagged with its PC, in a small circular FIFO, and
//   presents the FIFO head to decode. A redirect flushes the FIFO, restarts
//   fetch at the new PC and silently drops every response still in flight.
//
// Ports:
//   clk    - sole clock, rising edge
//   reset  - asynchronous, active-low
//   bus    - instr_fetch_queue_if.master: imem request/response, instruction
//            stream to decode, redirect input, flush_busy debug output
//
// Parameters:
//   DEPTH     - FIFO entries (power of two, >= 2)
//   MAX_OUTST - cap on memory requests in flight (1..DEPTH)
//   RESET_PC  - first fetch address after reset
// ---------------------------------------------------------------------------
module instr_fetch_queue #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MAX_OUTST = 2,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  instr_fetch_queue_if.master   bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned OST_W = $clog2(MAX_OUTST + 1);

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
  } entry_t;

  // Registered state
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      resp_pc_q,  resp_pc_d;
  logic [OST_W-1:0] outst_q,    outst_d;
  logic [OST_W-1:0] drop_q,     drop_d;
  logic [CNT_W-1:0] count_q,    count_d;
  logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
  logic             run_q,      run_d;
  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];

  // Per-cycle decode of the bus
  logic        req_valid;
  logic        req_fire;
  logic        rsp_drop;
  logic        rsp_take;
  logic        pop;
  logic [31:0] target_pc;

  always_comb begin
    // run_q holds off the first request until one edge after reset release.
    // This keeps imem_req_valid low during reset without a combinational
    // path from reset.
    //
    // Outstanding requests plus buffered entries never exceed DEPTH. Every
    // response therefore has a free slot, so overflow cannot happen.
    req_valid = run_q
             && ((32'(count_q) + 32'(outst_q)) < DEPTH)
             && (32'(outst_q) < MAX_OUTST)
             && (drop_q == '0)
             && !bus.redirect_valid;
    req_fire  = req_valid && bus.imem_req_ready;
    rsp_drop  = bus.imem_rsp_valid && (drop_q != '0);
    rsp_take  = bus.imem_rsp_valid && (drop_q == '0);
    pop       = (count_q != '0) && bus.instr_ready;
    target_pc = bus.redirect_pc & ~32'h3;

    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    run_d      = 1'b1;
    mem_d      = mem_q;

    if (bus.redirect_valid) begin
      // Redirect beats push and pop. Everything still in flight has to be
      // dropped when it returns. That is the current drop count plus outst.
      // A response landing this cycle is one of those and is already gone,
      // so it is subtracted here.
      fetch_pc_d = target_pc;
      resp_pc_d  = target_pc;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      outst_d    = '0;
      drop_d     = drop_q + outst_q - OST_W'(bus.imem_rsp_valid);
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (rsp_drop) begin
        drop_d = drop_q - OST_W'(1);
      end
      if (rsp_take) begin
        mem_d[wr_ptr_q] = '{data: bus.imem_rsp_data, pc: resp_pc_q};
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        resp_pc_d       = resp_pc_q + 32'd4;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(rsp_take) - CNT_W'(pop);
      outst_d = outst_q + OST_W'(req_fire) - OST_W'(rsp_take);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      run_q      <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      run_q      <= run_d;
    end
  end

  // Storage has no reset. Its contents only reach the outputs while
  // count != 0, and entries are always written before they are counted.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.instr_valid    = (count_q != '0);
  // The head is masked while the FIFO is empty. Stale entries left by a
  // flush are never visible, and the outputs read zero out of reset.
  assign bus.instr          = (count_q != '0) ? mem_q[rd_ptr_q].data : 32'h0;
  assign bus.instr_pc       = (count_q != '0) ? mem_q[rd_ptr_q].pc   : 32'h0;
  assign bus.flush_busy     = (drop_q != '0);

endmodule

// File: tb/tb_instr_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_queue
//   Directed bench for instr_fetch_queue (DEPTH=4, MAX_OUTST=2, RESET_PC=0).
//   A bus engine acts as an in-order memory with fixed latency and as the
//   decode stage. It drives inputs on the falling edge and samples 1 time
//   unit later. A scoreboard queue holds the PCs of accepted requests that
//   have not yet been delivered; a redirect empties it.
// ---------------------------------------------------------------------------
module tb_instr_fetch_queue;

  localparam int unsigned DEPTH     = 4;
  localparam int unsigned MAX_OUTST = 2;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instr_fetch_queue_if bus ();

  instr_fetch_queue #(
    .DEPTH     (DEPTH),
    .MAX_OUTST (MAX_OUTST),
    .RESET_PC  (RESET_PC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- bench state ----------------
  int n_checks = 0;
  int n_errors = 0;

  // Controls written by the main sequence and read by the engine.
  int          rdy_mode;   // 0: never ready, 1: always, 2: random
  int          dec_mode;   // same encoding, for instr_ready
  int          lat;        // memory latency in cycles
  int          redir_seq;
  logic [31:0] redir_pc;

  // Engine-owned state.
  int          step = 0;
  int          redir_seen = 0;
  logic [31:0] rsp_q [$];
  int          due_q [$];
  logic [31:0] exp_q [$];
  logic [31:0] exp_req;
  logic [31:0] last_req_addr;
  logic [31:0] last_del_pc;
  int          n_req;
  int          n_del;
  int          inflight;
  int          max_inflight;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- bus engine: memory model, decode, scoreboard ----------------
  initial begin : engine
    forever begin
      @(negedge clk);
      step++;
      if (!reset) begin
        rsp_q.delete();
        due_q.delete();
        exp_q.delete();
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.instr_ready    = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        exp_req      = RESET_PC;
        last_req_addr = 32'h0;
        last_del_pc  = 32'h0;
        n_req        = 0;
        n_del        = 0;
        inflight     = 0;
        max_inflight = 0;
        redir_seen   = redir_seq;
      end else begin
        if (rsp_q.size() != 0 && due_q[0] <= step) begin
          bus.imem_rsp_valid = 1'b1;
          bus.imem_rsp_data  = mem_f(rsp_q.pop_front());
          void'(due_q.pop_front());
          inflight--;
        end else begin
          bus.imem_rsp_valid = 1'b0;
          bus.imem_rsp_data  = 32'h0;
        end
        bus.imem_req_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : rdy_mode[0];
        bus.instr_ready    = (dec_mode == 2) ? 1'($urandom_range(0, 1)) : dec_mode[0];
        if (redir_seq != redir_seen) begin
          bus.redirect_valid = 1'b1;
          bus.redirect_pc    = redir_pc;
          redir_seen         = redir_seq;
        end else begin
          bus.redirect_valid = 1'b0;
          bus.redirect_pc    = 32'h0;
        end
        #1;
        if (bus.imem_req_valid && bus.imem_req_ready) begin
          check_eq("req_addr", bus.imem_req_addr, exp_req);
          rsp_q.push_back(bus.imem_req_addr);
          due_q.push_back(step + lat);
          exp_q.push_back(bus.imem_req_addr);
          exp_req       = exp_req + 32'd4;
          last_req_addr = bus.imem_req_addr;
          n_req++;
          inflight++;
          if (inflight > max_inflight) max_inflight = inflight;
        end
        if (bus.instr_valid && bus.instr_ready) begin
          if (exp_q.size() == 0) begin
            check_eq("instr_unexpected", bus.instr_pc, 32'hDEAD_BEEF);
          end else begin
            logic [31:0] pc;
            pc = exp_q.pop_front();
            check_eq("instr_pc", bus.instr_pc, pc);
            check_eq("instr_data", bus.instr, mem_f(pc));
          end
          last_del_pc = bus.instr_pc;
          n_del++;
        end
        if (bus.redirect_valid) begin
          exp_q.delete();
          exp_req = bus.redirect_pc & ~32'h3;
        end
      end
    end
  end

  // ---------------- sequencing helpers ----------------
  task automatic release_reset();
    @(posedge clk);
    #2 reset = 1'b1;
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #3 reset = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redir_pc  = pc;
    redir_seq = redir_seq + 1;
  endtask

  task automatic wait_nreq(input int target, input string tag);
    for (int i = 0; i < 500 && n_req < target; i++) @(posedge clk);
    check_eq(tag, 32'(n_req >= target), 32'd1);
  endtask

  task automatic wait_ndel(input int target, input string tag);
    for (int i = 0; i < 500 && n_del < target; i++) @(posedge clk);
    check_eq(tag, 32'(n_del >= target), 32'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int first_iv;
    int base_req;
    int base_del;
    rdy_mode  = 1;
    dec_mode  = 1;
    lat       = 1;
    redir_seq = 0;
    redir_pc  = 32'h0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #2;
    check_eq("rst_req_valid",   32'(bus.imem_req_valid), 32'd0);
    check_eq("rst_instr_valid", 32'(bus.instr_valid),    32'd0);
    check_eq("rst_instr",       bus.instr,               32'd0);
    check_eq("rst_instr_pc",    bus.instr_pc,            32'd0);
    check_eq("rst_flush_busy",  32'(bus.flush_busy),     32'd0);

    // Test 1: 1-cycle memory, decode always ready. The first instruction
    // shows up 3 cycles after release and then streams one per cycle.
    release_reset();
    first_iv = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #2;
      if (bus.instr_valid) begin
        first_iv = i;
        break;
      end
    end
    check_eq("first_valid_cycle", first_iv, 3);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #2;
      check_eq("stream_valid", 32'(bus.instr_valid), 32'd1);
    end
    check_eq("stream_first_pcs", 32'(n_del >= 8), 32'd1);

    // Test 2: decode stalled, so the FIFO fills to DEPTH and fetch stops.
    dec_mode = 0;
    apply_reset();
    release_reset();
    repeat (12) @(posedge clk);
    #2;
    check_eq("fill_nreq",        n_req,                   DEPTH);
    check_eq("fill_req_valid",   32'(bus.imem_req_valid), 32'd0);
    check_eq("fill_instr_valid", 32'(bus.instr_valid),    32'd1);
    check_eq("fill_head_pc",     bus.instr_pc,            32'h0);
    check_eq("fill_head_data",   bus.instr,               mem_f(32'h0));
    dec_mode = 1;
    wait_nreq(5, "resume_timeout");
    check_eq("resume_addr", last_req_addr, 32'h10);
    wait_ndel(4, "drain_timeout");

    // Test 3: latency 3, two requests in flight, then redirect to 0x103.
    lat      = 3;
    dec_mode = 1;
    apply_reset();
    release_reset();
    for (int i = 0; i < 50 && inflight != 2; i++) @(posedge clk);
    check_eq("two_outst", inflight, 2);
    do_redirect(32'h0000_0103);
    @(negedge clk); #2;
    check_eq("redir_kill_req", 32'(bus.imem_req_valid), 32'd0);
    @(negedge clk); #2;
    check_eq("flush_busy_1",  32'(bus.flush_busy),  32'd1);
    check_eq("flush_empty",   32'(bus.instr_valid), 32'd0);
    @(negedge clk); #2;
    check_eq("flush_busy_2",  32'(bus.flush_busy),  32'd1);
    @(negedge clk); #2;
    check_eq("flush_done",    32'(bus.flush_busy),     32'd0);
    check_eq("restart_valid", 32'(bus.imem_req_valid), 32'd1);
    check_eq("restart_addr",  bus.imem_req_addr,       32'h100);
    base_del = n_del;
    wait_ndel(base_del + 1, "redir_del_timeout");
    check_eq("redir_first_pc", last_del_pc, 32'h100);

    // Test 4: FIFO at its highest reachable occupancy, with a response
    // landing and a pop in the same cycle as a redirect.
    lat      = 1;
    dec_mode = 0;
    apply_reset();
    release_reset();
    wait_nreq(4, "t4_fill_timeout");
    repeat (4) @(posedge clk);
    dec_mode = 1;                       // pop 0: 4 -> 3 entries
    @(posedge clk);
    dec_mode = 0;                       // refill request for 0x10
    @(negedge clk); #2;
    check_eq("t4_req_valid", 32'(bus.imem_req_valid), 32'd1);
    check_eq("t4_req_addr",  bus.imem_req_addr,       32'h10);
    @(posedge clk);
    dec_mode = 1;                       // push(0x10) + pop(4) + redirect
    do_redirect(32'h0000_0200);
    @(negedge clk); #2;
    check_eq("t4_head_valid", 32'(bus.instr_valid), 32'd1);
    check_eq("t4_head_pc",    bus.instr_pc,         32'h4);
    @(negedge clk); #2;
    check_eq("t4_empty",      32'(bus.instr_valid),    32'd0);
    check_eq("t4_no_drop",    32'(bus.flush_busy),     32'd0);
    check_eq("t4_req_valid2", 32'(bus.imem_req_valid), 32'd1);
    check_eq("t4_req_addr2",  bus.imem_req_addr,       32'h200);
    base_del = n_del;
    wait_ndel(base_del + 2, "t4_del_timeout");
    check_eq("t4_last_pc", last_del_pc, 32'h204);

    // Test 5: random memory ready and decode ready, 1000 instructions.
    lat      = 2;
    rdy_mode = 2;
    dec_mode = 2;
    apply_reset();
    release_reset();
    for (int i = 0; i < 20000 && n_del < 1000; i++) @(posedge clk);
    check_eq("rand_ndel",  32'(n_del >= 1000), 32'd1);
    check_eq("rand_outst", 32'(max_inflight <= MAX_OUTST), 32'd1);

    // Test 6: PC wrap, then an asynchronous reset in the middle of a burst.
    lat      = 1;
    rdy_mode = 1;
    dec_mode = 1;
    apply_reset();
    release_reset();
    repeat (6) @(posedge clk);
    do_redirect(32'hFFFF_FFFF);
    @(posedge clk);
    base_req = n_req;
    base_del = n_del;
    wait_nreq(base_req + 1, "wrap_req1_timeout");
    check_eq("wrap_addr0", last_req_addr, 32'hFFFF_FFFC);
    wait_nreq(base_req + 2, "wrap_req2_timeout");
    check_eq("wrap_addr1", last_req_addr, 32'h0000_0000);
    wait_ndel(base_del + 3, "wrap_del_timeout");
    check_eq("wrap_del_pc", last_del_pc, 32'h0000_0004);

    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check_eq("mid_rst_req_valid",   32'(bus.imem_req_valid), 32'd0);
    check_eq("mid_rst_instr_valid", 32'(bus.instr_valid),    32'd0);
    check_eq("mid_rst_instr",       bus.instr,               32'd0);
    check_eq("mid_rst_instr_pc",    bus.instr_pc,            32'd0);
    check_eq("mid_rst_flush_busy",  32'(bus.flush_busy),     32'd0);
    repeat (2) @(posedge clk);
    release_reset();
    wait_nreq(1, "post_rst_timeout");
    check_eq("post_rst_addr", last_req_addr, RESET_PC);

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
